// File: rtl/mips_mem_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and load/store (DM),
// one transaction at a time; DM is favoured but IF is forced through after STARVE_MAX losses.
module mips_mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req_valid,
    output logic              dm_req_ready,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state;
    logic             owner_if;
    logic             req_we;
    logic [CNT_W-1:0] wait_cnt;
    logic [STV_W-1:0] starve_cnt;
    logic             starved;
    logic             grant_if;
    logic             grant_dm;

    assign starved = (starve_cnt == STV_W'(STARVE_MAX));

    // Ready is gated by reset so every output reads 0 while reset is held low.
    always_comb begin
        grant_dm = 1'b0;
        grant_if = 1'b0;
        if (reset && state == IDLE) begin
            grant_dm = dm_req_valid && (!if_req_valid || !starved);
            grant_if = if_req_valid && (!dm_req_valid || starved);
        end
    end

    assign if_req_ready = grant_if;
    assign dm_req_ready = grant_dm;
    assign busy         = (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner_if   <= 1'b0;
            req_we     <= 1'b0;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rvalid  <= 1'b0;
            dm_rvalid  <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_if || grant_dm) begin
                        state     <= ISSUE;
                        owner_if  <= grant_if;
                        req_we    <= grant_dm && dm_we;
                        mem_en    <= 1'b1;
                        mem_we    <= grant_dm && dm_we;
                        mem_addr  <= grant_if ? if_addr : dm_addr;
                        mem_wdata <= (grant_dm && dm_we) ? dm_wdata : '0;
                        if (grant_if) begin
                            starve_cnt <= '0;
                        end else if (if_req_valid && !starved) begin
                            starve_cnt <= starve_cnt + STV_W'(1);
                        end
                    end
                end
                ISSUE: begin
                    state     <= WAIT;
                    wait_cnt  <= CNT_W'(MEM_LAT - 1);
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                end
                WAIT: begin
                    // The last wait cycle is the one in which the memory presents its data.
                    if (wait_cnt == '0) begin
                        state     <= RESP;
                        if_rvalid <= owner_if;
                        dm_rvalid <= !owner_if;
                        if (!req_we) begin
                            if (owner_if) begin
                                if_rdata <= mem_rdata;
                            end else begin
                                dm_rdata <= mem_rdata;
                            end
                        end
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    if_rvalid <= 1'b0;
                    dm_rvalid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
